fetch_decode_ctrl: RTL and testbench
====================================

# fetch_decode_ctrl

Instruction sequencer that sits directly upstream of the program counter. It fetches each 16-bit instruction, decodes it, and maintains the processor flag register. It issues exactly one single-cycle PC-control pulse per instruction: `pcAdd`, `pcBranch` or `pcJump`. Alongside the pulse it drives `flagOp`, `immediate` and `flagRegister`, and the program counter consumes these.

## Interface
- `WIDTH`, 16, data/instruction/address width.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `instrIn`  in  WIDTH  instruction word from instruction memory.
- `instrValid`  in  1  `instrIn` valid this cycle.
- `fetchReq`  out  1  request an instruction at the current PC address.
- `jumpRegAddr`  out  4  register-file read index for jump targets (`instrReg[3:0]`).
- `jumpRegData`  in  WIDTH  register-file read data.
- `flagsIn`  in  5  ALU flags {N,Z,F,L,C} = bits [4:0].
- `aluEn`  out  1  one-cycle ALU execute strobe.
- `memReq`  out  1  data-memory request (load/store).
- `memWrite`  out  1  1 = store, 0 = load; valid while `memReq` is high.
- `memReady`  in  1  data-memory completion.
- `pcAdd`, `pcBranch`, `pcJump`  out  1 each  PC-control pulses; at most one is high in any cycle.
- `flagOp`  out  4  condition code (`instrReg[11:8]`).
- `immediate`  out  WIDTH  branch displacement or jump target.
- `flagRegister`  out  16  {11'b0, N, Z, F, L, C}; C=bit0, L=1, F=2, Z=3, N=4.
- `halted`  out  1  core halted (see Configuration).

## Operation
- Decode, from `instrReg`:
  - `[15:12]=4'hC` → Bcond. `immediate` = sign-extend(`[7:0]`).
  - `[15:12]=4'h4` and `[7:4]=4'hC` → Jcond. `immediate` = `jumpRegData`.
  - `[15:12]=4'h4` and `[7:4]=4'h0` → LOAD.
  - `[15:12]=4'h4` and `[7:4]=4'h4` → STOR.
  - All other encodings → ALU op.
- FSM states: FETCH, DECODE, EXEC, MEM, HALT. Reset state is FETCH.
- FETCH:
  - `fetchReq`=1.
  - On `instrValid`=1, latch `instrIn` into `instrReg` and go to DECODE.
  - Otherwise stay in FETCH; there is no timeout.
- DECODE:
  - Single cycle. `jumpRegAddr` is presented so that `jumpRegData` is stable in EXEC.
  - Go to EXEC.
- EXEC:
  - ALU op: `aluEn`=1 and `pcAdd`=1; `flagRegister[4:0]` <= `flagsIn` at this edge. Go to FETCH.
  - Bcond: `pcBranch`=1 with `flagOp` and `immediate` valid. Go to FETCH.
  - Jcond: `pcJump`=1 with `flagOp` and `immediate` valid. Go to FETCH.
  - LOAD/STOR: `memReq`=1, `memWrite` per opcode. Go to MEM.
- MEM:
  - `memReq` is held at 1 until `memReady`=1.
  - In the `memReady` cycle: `pcAdd`=1 and `memReq`=1; next state is FETCH.
- The branch/jump condition is evaluated by the PC stage, not here. This block pulses `pcBranch`/`pcJump` unconditionally.
- `flagRegister` changes only on ALU ops. Branches, jumps and memory operations preserve it.

## Timing
- Reset values:
  - State FETCH.
  - `instrReg` = 0, `flagRegister` = 0, `flagOp` = 0, `immediate` = 0.
  - All strobes 0: `fetchReq`, `aluEn`, `memReq`, `memWrite`, `pcAdd`, `pcBranch`, `pcJump`.
  - `halted` = 0.
- Reset mid-operation:
  - Asynchronous assertion forces all reset values immediately from any state, including mid-MEM.
  - `memReq` drops in the same cycle; no PC pulse is emitted.
- Latency with `instrValid` already high in FETCH:
  - ALU, branch or jump instruction: 3 cycles (FETCH, DECODE, EXEC).
  - Memory instruction: 3 cycles + (N+1) cycles, where `memReady` arrives N cycles after MEM entry.
- Pulses: `pcAdd`/`pcBranch`/`pcJump`/`aluEn` are high for exactly one cycle per instruction.
- Output stability: `flagOp` and `immediate` are registered from `instrReg` and stable from DECODE through the pulse cycle. `flagRegister` is registered.
- `fetchReq` is low in every state except FETCH. `instrValid` outside FETCH is ignored.
- Simultaneous `instrValid` and reset release: reset dominates, and the first valid sample is taken on the next edge.

## Configuration
- Macro: `TRON_HALT_DETECT_EN`.
- Defined:
  - A Bcond with `flagOp`=4'b1110 (UC) and `[7:0]`=8'hFF (branch-to-self) goes EXEC→HALT with no `pcBranch` pulse.
  - `halted`=1 and all strobes stay 0 until reset.
- Undefined:
  - The HALT state is not built and `halted` is tied 0.
  - The same instruction issues `pcBranch` with `immediate`=16'hFFFF, forming a normal self-loop.

## Test plan
- ALU op: `instrIn`=16'h0123, `flagsIn`=5'b01000, `instrValid` high → `aluEn` and `pcAdd` pulse 3 cycles after reset release; `flagRegister`=16'h0008.
- Bcond: `instrIn`=16'hC0FE → `pcBranch` pulse, `flagOp`=0, `immediate`=16'hFFFE; `flagRegister` unchanged.
- Jcond: `instrIn`=16'h4EC5, `jumpRegData`=16'h0040 → `jumpRegAddr`=5, `pcJump` pulse, `flagOp`=4'hE, `immediate`=16'h0040.
- Load with `memReady` delayed 4 cycles → `memReq` high for 5 cycles, `memWrite`=0, `pcAdd` pulses in the `memReady` cycle; reset asserted mid-wait → `memReq` drops immediately and there is no `pcAdd`.
- Halt: `instrIn`=16'hCEFF → with the macro defined, `halted`=1 with no pulses; without it, `pcBranch` pulses with `immediate`=16'hFFFF.

Source files
------------

// File: rtl/fetch_decode_ctrl.sv
// rtl/fetch_decode_ctrl.sv - fetch/decode sequencer issuing one PC-control pulse per instruction
// Optional TRON_HALT_DETECT_EN: unconditional branch-to-self parks the core in HALT.
module fetch_decode_ctrl #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] instrIn,
   input  logic             instrValid,
   output logic             fetchReq,
   output logic [3:0]       jumpRegAddr,
   input  logic [WIDTH-1:0] jumpRegData,
   input  logic [4:0]       flagsIn,
   output logic             aluEn,
   output logic             memReq,
   output logic             memWrite,
   input  logic             memReady,
   output logic             pcAdd,
   output logic             pcBranch,
   output logic             pcJump,
   output logic [3:0]       flagOp,
   output logic [WIDTH-1:0] immediate,
   output logic [15:0]      flagRegister,
   output logic             halted
);

`ifdef TRON_HALT_DETECT_EN
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_HALT} state_t;
`else
   typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM} state_t;
`endif

   state_t           state_q, state_d;
   logic [WIDTH-1:0] instr_reg_q, instr_reg_d;
   logic [15:0]      flag_reg_q, flag_reg_d;
   logic [3:0]       flag_op_q, flag_op_d;
   logic [WIDTH-1:0] imm_q, imm_d;
   logic             fetch_req_q, fetch_req_d;
   logic             alu_en_q, alu_en_d;
   logic             mem_req_q, mem_req_d;
   logic             mem_write_q, mem_write_d;
   logic             pc_add_q, pc_add_d;
   logic             pc_branch_q, pc_branch_d;
   logic             pc_jump_q, pc_jump_d;
   logic             halted_q, halted_d;

   logic is_bcond, is_jcond, is_load, is_stor, is_alu, halt_hit;

   always_comb begin
      is_bcond = (instr_reg_q[15:12] == 4'hC);
      is_jcond = (instr_reg_q[15:12] == 4'h4) && (instr_reg_q[7:4] == 4'hC);
      is_load  = (instr_reg_q[15:12] == 4'h4) && (instr_reg_q[7:4] == 4'h0);
      is_stor  = (instr_reg_q[15:12] == 4'h4) && (instr_reg_q[7:4] == 4'h4);
      is_alu   = !(is_bcond || is_jcond || is_load || is_stor);
`ifdef TRON_HALT_DETECT_EN
      halt_hit = is_bcond && (instr_reg_q[11:8] == 4'hE) && (instr_reg_q[7:0] == 8'hFF);
`else
      halt_hit = 1'b0;
`endif
   end

   always_comb begin
      state_d     = state_q;
      instr_reg_d = instr_reg_q;
      flag_reg_d  = flag_reg_q;
      flag_op_d   = flag_op_q;
      imm_d       = imm_q;
      fetch_req_d = 1'b0;
      alu_en_d    = 1'b0;
      mem_req_d   = 1'b0;
      mem_write_d = 1'b0;
      pc_add_d    = 1'b0;
      pc_branch_d = 1'b0;
      pc_jump_d   = 1'b0;
      halted_d    = 1'b0;
      // Strobes are registered: each is set on the edge that enters the state it belongs to.
      case (state_q)
         S_FETCH: begin
            if (instrValid) begin
               instr_reg_d = instrIn;
               flag_op_d   = instrIn[11:8];
               imm_d       = {{(WIDTH-8){instrIn[7]}}, instrIn[7:0]};
               state_d     = S_DECODE;
            end else begin
               fetch_req_d = 1'b1;
            end
         end
         S_DECODE: begin
            state_d = S_EXEC;
            if (is_jcond) imm_d = jumpRegData;
            if (is_alu) begin
               alu_en_d = 1'b1;
               pc_add_d = 1'b1;
            end else if (is_bcond) begin
               pc_branch_d = !halt_hit;
            end else if (is_jcond) begin
               pc_jump_d = 1'b1;
            end else begin
               mem_req_d   = 1'b1;
               mem_write_d = is_stor;
            end
         end
         S_EXEC: begin
            if (is_alu) flag_reg_d = {11'b0, flagsIn};
            if (is_load || is_stor) begin
               state_d     = S_MEM;
               mem_req_d   = 1'b1;
               mem_write_d = mem_write_q;
`ifdef TRON_HALT_DETECT_EN
            end else if (halt_hit) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
`endif
            end else begin
               state_d     = S_FETCH;
               fetch_req_d = 1'b1;
            end
         end
         S_MEM: begin
            if (memReady) begin
               state_d     = S_FETCH;
               fetch_req_d = 1'b1;
            end else begin
               mem_req_d   = 1'b1;
               mem_write_d = mem_write_q;
            end
         end
`ifdef TRON_HALT_DETECT_EN
         S_HALT: halted_d = 1'b1;
`endif
         default: state_d = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_FETCH;
         instr_reg_q <= '0;
         flag_reg_q  <= '0;
         flag_op_q   <= '0;
         imm_q       <= '0;
         fetch_req_q <= 1'b0;
         alu_en_q    <= 1'b0;
         mem_req_q   <= 1'b0;
         mem_write_q <= 1'b0;
         pc_add_q    <= 1'b0;
         pc_branch_q <= 1'b0;
         pc_jump_q   <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         instr_reg_q <= instr_reg_d;
         flag_reg_q  <= flag_reg_d;
         flag_op_q   <= flag_op_d;
         imm_q       <= imm_d;
         fetch_req_q <= fetch_req_d;
         alu_en_q    <= alu_en_d;
         mem_req_q   <= mem_req_d;
         mem_write_q <= mem_write_d;
         pc_add_q    <= pc_add_d;
         pc_branch_q <= pc_branch_d;
         pc_jump_q   <= pc_jump_d;
         halted_q    <= halted_d;
      end
   end

   // Memory completion advances the PC in the same cycle memReady is seen.
   assign pcAdd        = pc_add_q | ((state_q == S_MEM) && memReady);
   assign pcBranch     = pc_branch_q;
   assign pcJump       = pc_jump_q;
   assign fetchReq     = fetch_req_q;
   assign aluEn        = alu_en_q;
   assign memReq       = mem_req_q;
   assign memWrite     = mem_write_q;
   assign flagOp       = flag_op_q;
   assign immediate    = imm_q;
   assign flagRegister = flag_reg_q;
   assign halted       = halted_q;
   assign jumpRegAddr  = instr_reg_q[3:0];

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// tb/tb_fetch_decode_ctrl.sv - scoreboard bench for fetch_decode_ctrl
module tb_fetch_decode_ctrl;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] instrIn = '0;
   logic        instrValid = 1'b0;
   logic        fetchReq;
   logic [3:0]  jumpRegAddr;
   logic [15:0] jumpRegData = '0;
   logic [4:0]  flagsIn = '0;
   logic        aluEn, memReq, memWrite;
   logic        memReady = 1'b0;
   logic        pcAdd, pcBranch, pcJump;
   logic [3:0]  flagOp;
   logic [15:0] immediate;
   logic [15:0] flagRegister;
   logic        halted;

   fetch_decode_ctrl #(.WIDTH(16)) dut (
      .clk(clk), .reset(reset), .instrIn(instrIn), .instrValid(instrValid),
      .fetchReq(fetchReq), .jumpRegAddr(jumpRegAddr), .jumpRegData(jumpRegData),
      .flagsIn(flagsIn), .aluEn(aluEn), .memReq(memReq), .memWrite(memWrite),
      .memReady(memReady), .pcAdd(pcAdd), .pcBranch(pcBranch), .pcJump(pcJump),
      .flagOp(flagOp), .immediate(immediate), .flagRegister(flagRegister), .halted(halted)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  pulses;
      logic        alu;
      logic        mreq;
      logic        mwr;
      logic [3:0]  fop;
      logic [15:0] imm;
      logic        chk_imm;
      logic [3:0]  jra;
      logic        chk_jra;
   } exp_t;

   exp_t q[$];
   int vectors = 0;
   int miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic void expect_ev(input logic [2:0] p, input logic alu, input logic mreq,
                                     input logic mwr, input logic [3:0] fop, input logic [15:0] imm,
                                     input logic ci, input logic [3:0] jra, input logic cj);
      exp_t e;
      e.pulses = p; e.alu = alu; e.mreq = mreq; e.mwr = mwr; e.fop = fop;
      e.imm = imm; e.chk_imm = ci; e.jra = jra; e.chk_jra = cj;
      q.push_back(e);
   endfunction

   always @(negedge clk) begin : monitor
      exp_t e;
      if (reset && (pcAdd || pcBranch || pcJump)) begin
         if (q.size() == 0) begin
            check("unexpected_pulse", 32'({pcAdd, pcBranch, pcJump}), 32'd0);
         end else begin
            e = q.pop_front();
            check("pulse_kind", 32'({pcAdd, pcBranch, pcJump}), 32'(e.pulses));
            check("alu_en", 32'(aluEn), 32'(e.alu));
            check("mem_req_at_pulse", 32'(memReq), 32'(e.mreq));
            if (e.mreq) check("mem_write_at_pulse", 32'(memWrite), 32'(e.mwr));
            check("flag_op", 32'(flagOp), 32'(e.fop));
            if (e.chk_imm) check("immediate", 32'(immediate), 32'(e.imm));
            if (e.chk_jra) check("jump_reg_addr", 32'(jumpRegAddr), 32'(e.jra));
         end
      end
   end

   task automatic wait_fetch();
      int n = 0;
      @(negedge clk);
      while (!fetchReq && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!fetchReq) check("fetch_timeout", 32'(fetchReq), 32'd1);
   endtask

   task automatic issue(input logic [15:0] instr);
      wait_fetch();
      instrIn    = instr;
      instrValid = 1'b1;
      @(posedge clk);
      #1;
      instrValid = 1'b0;
      instrIn    = 16'h4040;
   endtask

   task automatic mem_op(input logic [15:0] instr, input logic wr, input int dly);
      int cnt = 0;
      int n = 0;
      expect_ev(3'b100, 1'b0, 1'b1, wr, instr[11:8], 16'h0, 1'b0, instr[3:0], 1'b1);
      issue(instr);
      @(negedge clk);
      while (!memReq && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("mem_req_rise", 32'(memReq), 32'd1);
      check("mem_write", 32'(memWrite), 32'(wr));
      cnt = 1;
      for (int c = 1; c <= dly; c++) begin
         @(posedge clk);
         #1;
         if (c == dly) memReady = 1'b1;
         @(negedge clk);
         if (memReq) cnt++;
      end
      @(posedge clk);
      #1;
      memReady = 1'b0;
      @(negedge clk);
      check("mem_req_drop", 32'(memReq), 32'd0);
      check("mem_req_cycles", 32'(cnt), 32'(dly + 1));
   endtask

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin : stim
      instrIn     = 16'h0123;
      instrValid  = 1'b1;
      flagsIn     = 5'b01000;
      jumpRegData = 16'h0040;
      repeat (3) @(negedge clk);
      check("rst_fetch_req", 32'(fetchReq), 32'd0);
      check("rst_flag_reg", 32'(flagRegister), 32'd0);
      check("rst_flag_op", 32'(flagOp), 32'd0);
      check("rst_immediate", 32'(immediate), 32'd0);
      check("rst_strobes", 32'({aluEn, memReq, memWrite, pcAdd, pcBranch, pcJump}), 32'd0);
      check("rst_halted", 32'(halted), 32'd0);

      // ALU op with instrValid already high at reset release
      expect_ev(3'b100, 1'b1, 1'b0, 1'b0, 4'h1, 16'h0, 1'b0, 4'h3, 1'b1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      instrValid = 1'b0;
      instrIn    = 16'h4040;
      @(negedge clk);
      check("alu_latency_decode", 32'(pcAdd), 32'd0);
      @(negedge clk);
      check("alu_latency_exec", 32'(pcAdd), 32'd1);
      @(negedge clk);
      check("alu_flag_reg", 32'(flagRegister), 32'h0008);
      check("alu_pulse_single", 32'({aluEn, pcAdd}), 32'd0);
      check("fetch_req_back", 32'(fetchReq), 32'd1);

      // Bcond must not touch flags
      flagsIn = 5'b10101;
      expect_ev(3'b010, 1'b0, 1'b0, 1'b0, 4'h0, 16'hFFFE, 1'b1, 4'hE, 1'b1);
      issue(16'hC0FE);
      wait_fetch();
      check("bcond_flags_kept", 32'(flagRegister), 32'h0008);

      expect_ev(3'b001, 1'b0, 1'b0, 1'b0, 4'hE, 16'h0040, 1'b1, 4'h5, 1'b1);
      issue(16'h4EC5);
      wait_fetch();
      check("jcond_flags_kept", 32'(flagRegister), 32'h0008);

      expect_ev(3'b100, 1'b1, 1'b0, 1'b0, 4'h2, 16'h0, 1'b0, 4'h4, 1'b1);
      issue(16'h1234);
      wait_fetch();
      check("alu2_flag_reg", 32'(flagRegister), 32'h0015);

      flagsIn = 5'b00010;
      mem_op(16'h4143, 1'b1, 2);
      mem_op(16'h4007, 1'b0, 4);
      check("mem_flags_kept", 32'(flagRegister), 32'h0015);

      // Reset in the middle of a memory wait, coinciding with memReady
      issue(16'h4002);
      @(negedge clk);
      @(negedge clk);
      check("mid_mem_req", 32'(memReq), 32'd1);
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      reset    = 1'b0;
      memReady = 1'b1;
      #1;
      check("reset_mem_req_drop", 32'(memReq), 32'd0);
      check("reset_no_pcadd", 32'(pcAdd), 32'd0);
      check("reset_flag_reg", 32'(flagRegister), 32'd0);
      @(negedge clk);
      memReady = 1'b0;
      reset    = 1'b1;

`ifdef TRON_HALT_DETECT_EN
      issue(16'hCEFF);
      repeat (5) @(negedge clk);
      check("halt_halted", 32'(halted), 32'd1);
      check("halt_strobes", 32'({fetchReq, aluEn, memReq, pcAdd, pcBranch, pcJump}), 32'd0);
`else
      expect_ev(3'b010, 1'b0, 1'b0, 1'b0, 4'hE, 16'hFFFF, 1'b1, 4'hF, 1'b1);
      issue(16'hCEFF);
      wait_fetch();
      check("selfloop_not_halted", 32'(halted), 32'd0);
`endif

      repeat (2) @(negedge clk);
      check("scoreboard_empty", 32'(q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
